// File: rtl/ram_block_copier.sv
// Copies a block of bytes inside a single-port synchronous RAM, one READ/WRITE pair per byte.
// Optional fill mode (constant write, one byte per cycle) is enabled with RAM_BLOCK_COPIER_FILL_EN.
module ram_block_copier #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
`ifdef RAM_BLOCK_COPIER_FILL_EN
    input  logic                  fill_mode,
    input  logic [DATA_WIDTH-1:0] fill_value,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_write_enable,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   src_q, src_d;
    logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;

    logic                    start_ok_s;
    logic                    fill_req_s;
    logic                    fill_act_s;
    logic [DATA_WIDTH-1:0]   fill_data_s;

    // abort always beats start, and start only counts while idle
    assign start_ok_s = (state_q == ST_IDLE) && start && !abort;

`ifdef RAM_BLOCK_COPIER_FILL_EN
    logic                    fill_q, fill_d;
    logic [DATA_WIDTH-1:0]   fill_val_q, fill_val_d;

    assign fill_req_s  = fill_mode;
    assign fill_act_s  = fill_q;
    assign fill_data_s = fill_val_q;

    // Capture the fill configuration together with the transfer parameters
    always_comb begin
        fill_d     = fill_q;
        fill_val_d = fill_val_q;
        if (start_ok_s && (length != CNT_ZERO)) begin
            fill_d     = fill_mode;
            fill_val_d = fill_value;
        end else begin
            fill_d     = fill_q;
            fill_val_d = fill_val_q;
        end
    end

    // Fill configuration registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fill_q     <= 1'b0;
            fill_val_q <= {DATA_WIDTH{1'b0}};
        end else begin
            fill_q     <= fill_d;
            fill_val_q <= fill_val_d;
        end
    end
`else
    assign fill_req_s  = 1'b0;
    assign fill_act_s  = 1'b0;
    assign fill_data_s = {DATA_WIDTH{1'b0}};
`endif

    // Next-state, address and count logic
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    if (length == CNT_ZERO) begin
                        state_d = ST_DONE;
                    end else begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        cnt_d   = length;
                        state_d = fill_req_s ? ST_WRITE : ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    // addresses wrap naturally at the register width
                    src_d = src_q + ADDR_ONE;
                    dst_d = dst_q + ADDR_ONE;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q > CNT_ONE) begin
                        state_d = fill_act_s ? ST_WRITE : ST_READ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, address and count registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            src_q   <= {ADDR_WIDTH{1'b0}};
            dst_q   <= {ADDR_WIDTH{1'b0}};
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
        end
    end

    // RAM port and status decode; abort gates the write strobe without waiting for a clock
    always_comb begin
        busy             = (state_q != ST_IDLE);
        done             = (state_q == ST_DONE);
        ram_address      = {ADDR_WIDTH{1'b0}};
        ram_data_in      = {DATA_WIDTH{1'b0}};
        ram_write_enable = 1'b0;
        case (state_q)
            ST_READ: begin
                ram_address = src_q;
            end
            ST_WRITE: begin
                ram_address      = dst_q;
                ram_data_in      = fill_act_s ? fill_data_s : ram_data_out;
                ram_write_enable = !abort;
            end
            ST_IDLE: begin
                ram_address = {ADDR_WIDTH{1'b0}};
            end
            ST_DONE: begin
                ram_address = {ADDR_WIDTH{1'b0}};
            end
            default: begin
                ram_address = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_ram_block_copier.sv
// Self-checking bench for ram_block_copier: table vectors, randomized copies against a
// byte-wise memcpy reference, and hand sequences for abort, reset and ignored starts.
module tb_ram_block_copier;

    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int LW   = AW + 1;
    localparam int LOGN = 4096;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   length = '0;
`ifdef RAM_BLOCK_COPIER_FILL_EN
    logic          fill_mode = 1'b0;
    logic [DW-1:0] fill_value = '0;
`endif
    logic          busy, done, ram_write_enable;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;

    ram_block_copier #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
`ifdef RAM_BLOCK_COPIER_FILL_EN
        .fill_mode(fill_mode), .fill_value(fill_value),
`endif
        .busy(busy), .done(done), .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
    );

    always #5 clock = ~clock;

    // Synchronous single-port RAM with a bench-side preload port
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_write_enable) mem[ram_address] <= ram_data_in;
        ram_data_out <= mem[ram_address];
    end

    // Bus monitor: logs every write, every read access, and done pulses
    logic [AW-1:0] wr_a [0:LOGN-1];
    logic [DW-1:0] wr_d [0:LOGN-1];
    logic [AW-1:0] rd_a [0:LOGN-1];
    int wr_n = 0;
    int rd_n = 0;
    int done_n = 0;
    always @(posedge clock) begin
        if (ram_write_enable && wr_n < LOGN) begin
            wr_a[wr_n] <= ram_address;
            wr_d[wr_n] <= ram_data_in;
            wr_n <= wr_n + 1;
        end
        if (busy && !done && !ram_write_enable && rd_n < LOGN) begin
            rd_a[rd_n] <= ram_address;
            rd_n <= rd_n + 1;
        end
        if (done) done_n <= done_n + 1;
    end

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " idle_busy"}, 32'(busy), 32'd0);
        chk({nm, " idle_done"}, 32'(done), 32'd0);
        chk({nm, " idle_we"}, 32'(ram_write_enable), 32'd0);
        chk({nm, " idle_addr"}, 32'(ram_address), 32'd0);
        chk({nm, " idle_din"}, 32'(ram_data_in), 32'd0);
    endtask

    // One full transfer; the expected write stream is an ascending byte-by-byte memcpy
    task automatic run_copy(input string nm, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input int n, input bit fill, input logic [DW-1:0] fv,
                            input int exp_cyc, input int poke);
        logic [AW-1:0] exp_a [$];
        logic [DW-1:0] exp_d [$];
        logic [AW-1:0] a;
        int w0, r0, d0, cyc, errs;
        bit seen;
        for (int i = 0; i < n; i++) begin
            a = d + AW'(i);
            exp_a.push_back(a);
            if (fill) begin
                exp_d.push_back(fv);
            end else begin
                a = s + AW'(i);
                exp_d.push_back(ref_mem[a]);
            end
            ref_mem[exp_a[i]] = exp_d[i];
        end
        @(negedge clock);
        w0 = wr_n; r0 = rd_n; d0 = done_n;
        src_addr = s; dst_addr = d; length = LW'(n); start = 1'b1;
`ifdef RAM_BLOCK_COPIER_FILL_EN
        fill_mode = fill; fill_value = fv;
`endif
        @(negedge clock);
        start = 1'b0;
        src_addr = AW'($urandom); dst_addr = AW'($urandom); length = LW'($urandom);
        seen = 1'b0;
        for (cyc = 1; cyc <= exp_cyc + 8; cyc++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = (cyc == poke);
            @(negedge clock);
        end
        start = 1'b0;
        chk({nm, " done_seen"}, 32'(seen), 32'd1);
        chk({nm, " done_cycle"}, cyc, exp_cyc);
        chk({nm, " busy_at_done"}, 32'(busy), 32'd1);
        @(negedge clock);
        chk_idle({nm, " after"});
        chk({nm, " done_pulses"}, done_n - d0, 32'd1);
        chk({nm, " write_count"}, wr_n - w0, n);
        errs = 0;
        for (int i = 0; i < n && (w0 + i) < wr_n; i++)
            if (wr_a[w0+i] !== exp_a[i] || wr_d[w0+i] !== exp_d[i]) errs++;
        chk({nm, " write_log"}, errs, 32'd0);
        if (!fill) begin
            chk({nm, " read_count"}, rd_n - r0, n);
            errs = 0;
            for (int i = 0; i < n && (r0 + i) < rd_n; i++) begin
                a = s + AW'(i);
                if (rd_a[r0+i] !== a) errs++;
            end
            chk({nm, " read_log"}, errs, 32'd0);
        end
        errs = 0;
        for (int i = 0; i < n; i++)
            if (mem[exp_a[i]] !== ref_mem[exp_a[i]]) errs++;
        chk({nm, " ram_contents"}, errs, 32'd0);
    endtask

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        int            len;
        int            exp_cyc;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int n, w0, d0;
        logic [AW-1:0] s, d;

        vecs[0] = '{16'h0100, 16'h0200, 4, 9};
        vecs[1] = '{16'hFFFE, 16'h0010, 3, 7};
        vecs[2] = '{16'h0040, 16'h0050, 0, 1};
        vecs[3] = '{16'h0300, 16'h0301, 5, 11};
        vecs[4] = '{16'h0410, 16'h040E, 4, 9};
        vecs[5] = '{16'h1234, 16'hFFFD, 6, 13};
        vecs[6] = '{16'h2000, 16'h2100, 1, 3};

        #1 reset = 1'b1;
        #1 chk_idle("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk_idle("post_reset");

        // Table-driven transfers
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < vecs[v].len; i++)
                preload(vecs[v].src + AW'(i), DW'(17 * (i + 1)));
            run_copy($sformatf("vec%0d", v), vecs[v].src, vecs[v].dst, vecs[v].len,
                     1'b0, 8'h00, vecs[v].exp_cyc, 0);
        end

        // abort together with start in IDLE: nothing starts
        @(negedge clock);
        w0 = wr_n; d0 = done_n;
        src_addr = 16'h0100; dst_addr = 16'h0500; length = 17'd3;
        start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        chk("abort_start busy", 32'(busy), 32'd0);
        repeat (6) @(negedge clock);
        chk("abort_start writes", wr_n - w0, 32'd0);
        chk("abort_start done", done_n - d0, 32'd0);

        // start pulsed mid-transfer is ignored
        for (int i = 0; i < 3; i++) preload(16'h0520 + AW'(i), DW'(8'hC0 + i));
        run_copy("ignored_start", 16'h0520, 16'h0540, 3, 1'b0, 8'h00, 7, 3);

        // abort in the second WRITE of a 5-byte copy
        for (int i = 0; i < 5; i++) preload(16'h0600 + AW'(i), DW'(8'h60 + i));
        @(negedge clock);
        w0 = wr_n; d0 = done_n;
        src_addr = 16'h0600; dst_addr = 16'h0700; length = 17'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("abort pre_we", 32'(ram_write_enable), 32'd1);
        abort = 1'b1;
        #1 chk("abort we_gated", 32'(ram_write_enable), 32'd0);
        @(negedge clock);
        abort = 1'b0;
        chk("abort busy_next", 32'(busy), 32'd0);
        chk("abort done_next", 32'(done), 32'd0);
        repeat (4) @(negedge clock);
        ref_mem[16'h0700] = ref_mem[16'h0600];
        chk("abort writes", wr_n - w0, 32'd1);
        chk("abort wr_addr", 32'(wr_a[w0]), 32'h0700);
        chk("abort wr_data", 32'(wr_d[w0]), 32'(ref_mem[16'h0700]));
        chk("abort done", done_n - d0, 32'd0);

        // asynchronous reset in the middle of a copy
        for (int i = 0; i < 6; i++) preload(16'h0800 + AW'(i), DW'(8'h80 + i));
        @(negedge clock);
        w0 = wr_n; d0 = done_n;
        src_addr = 16'h0800; dst_addr = 16'h0900; length = 17'd6; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1 chk_idle("mid_reset");
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        ref_mem[16'h0900] = ref_mem[16'h0800];
        chk("mid_reset writes", wr_n - w0, 32'd1);
        chk("mid_reset done", done_n - d0, 32'd0);
        run_copy("after_reset", 16'h0800, 16'h0A00, 6, 1'b0, 8'h00, 13, 0);

`ifdef RAM_BLOCK_COPIER_FILL_EN
        run_copy("fill", 16'h0000, 16'h0300, 4, 1'b1, 8'hA5, 5, 0);
        run_copy("fill_wrap", 16'h1111, 16'hFFFE, 3, 1'b1, 8'h3C, 4, 0);
`endif

        // Randomized copies, including overlap and wrap
        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(1, 12);
            s = AW'($urandom);
            case ($urandom_range(0, 2))
                0:       d = AW'($urandom);
                1:       d = s + AW'($urandom_range(1, 3));
                default: d = s - AW'($urandom_range(1, 3));
            endcase
            for (int i = 0; i < n; i++) preload(s + AW'(i), DW'($urandom));
            run_copy($sformatf("rand%0d", t), s, d, n, 1'b0, 8'h00, 2 * n + 1,
                     (t % 3 == 0) ? int'($urandom_range(1, 2 * n)) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
